debugport_uart_tx: RTL and testbench
====================================

// Module: debugport_uart_tx
// PURPOSE
//  Downstream consumer of the 8-bit debugport output of the data-bus debug peripheral.
//  - Detects every change of debugport and queues the new value in a small FIFO.
//  - Serialises queued values on a UART TX line (8N1, LSB first) so firmware progress codes reach a host terminal.
//  - Clocked in the processor block clock domain; uart_tx drives a board pin.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per UART bit (100 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    8    queue entries; power of 2, >= 2
// PORTS
//  clk         in   1             processor block clock, rising edge
//  rst         in   1             reset; asynchronous, active-high
//  debugport   in   8             debug byte from the debug peripheral
//  uart_tx     out  1             serial output; idle high
//  busy        out  1             1 when FSM not IDLE or FIFO not empty
//  overflow    out  1             sticky; a change was dropped because the FIFO was full
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset values: uart_tx=1, busy=0, overflow=0, fifo_level=0.
//  - Reset clears the internal state: prev=8'h00, FIFO empty, FSM=IDLE.
//  - Reset mid-frame aborts the frame: uart_tx goes high asynchronously and queued data is discarded.
//  - Change detect: prev <= debugport every cycle; change = (debugport != prev).
//  - Push on change: if not full, push debugport at the next edge.
//  - A nonzero debugport right after reset therefore produces one push.
//  - Full: the push is dropped and overflow <= 1. overflow clears only on reset.
//  - Full is evaluated before a same-cycle pop: push on a full FIFO is dropped even if IDLE pops that cycle.
//  - FIFO: circular buffer. Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//    Level is updated by +1 (push only), -1 (pop only), or 0 (both).
//  - FSM states and transitions:
//    - IDLE: uart_tx=1. If FIFO not empty: pop head into shift register, bit counter=0, baud counter=0 -> START.
//    - START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA.
//    - DATA: uart_tx=shift[0]; after CLKS_PER_BIT cycles shift right, bit_cnt+1. After bit 7 -> STOP.
//    - STOP: uart_tx=1 for CLKS_PER_BIT cycles -> IDLE.
//  - uart_tx is driven from a register (glitch-free).
//  - Baud counter counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
//  - Latency: debugport changes after edge k; push occurs at edge k+1; pop/IDLE->START at edge k+2; uart_tx low from edge k+2.
//  - Frame length: exactly 10*CLKS_PER_BIT cycles from START entry to IDLE re-entry.
//  - Back-to-back frames: one IDLE cycle between a STOP end and the next START.
//  - busy = (state != IDLE) || (fifo_level != 0), registered-equivalent (no combinational path from debugport).
// CONFIGURATION
//  DEBUGPORT_HEX_EN defined:
//   - Each popped byte B is sent as 4 frames in order:
//     ASCII hex of B[7:4], ASCII hex of B[3:0] (uppercase, '0'-'9','A'-'F'), 8'h0D, 8'h0A.
//   - A 2-bit char index sequences the frames: STOP->START directly (no IDLE cycle) between chars of one entry.
//   - The pop happens only at the first char.
//  DEBUGPORT_HEX_EN undefined: raw byte, one frame per entry, no char index logic.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Release reset with debugport=8'h00, hold 100 cycles.
//     -> uart_tx stays 1, busy=0, fifo_level=0, overflow=0.
//  2. Set debugport=8'hA5 after edge 10.
//     -> push at edge 11; uart_tx low from edge 12 for 4 cycles.
//     -> Bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each, then stop high.
//     -> busy falls after 40 cycles.
//  3. Write 8'h01,02,03,04,05,06 on consecutive cycles.
//     -> Frames received are 01..05 in order; 06 dropped; overflow=1 and stays 1.
//     -> Exactly one IDLE cycle between frames.
//  4. Hold debugport=8'h33 for 200 cycles after one change.
//     -> Exactly one frame (0x33) sent; no repeat pushes.
//  5. Assert rst 15 cycles into a frame with 2 entries queued.
//     -> uart_tx=1 immediately, fifo_level=0, busy=0.
//     -> After release, no further frames until debugport changes.
//  6. DEBUGPORT_HEX_EN defined, debugport=8'h3C.
//     -> Frames 0x33 ('3'), 0x43 ('C'), 0x0D, 0x0A; total 160 cycles; single pop.

Source files
------------

// File: rtl/debugport_uart_tx.sv
// Queues every change of the debug byte and sends it out as 8N1 UART frames, LSB first.
// Define DEBUGPORT_HEX_EN to send each byte as two uppercase ASCII hex digits followed by CR LF.
module debugport_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    debugport,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [7:0]      prev_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            overflow_q;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            change, full, push, pop, baud_last;
    logic [7:0]      head;

`ifdef DEBUGPORT_HEX_EN
    logic [7:0]      byte_q, byte_d;
    logic [1:0]      chr_q, chr_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] char_sel(input logic [7:0] b, input logic [1:0] idx);
        case (idx)
            2'd0:    return hex_ascii(b[7:4]);
            2'd1:    return hex_ascii(b[3:0]);
            2'd2:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction
`endif

    assign change    = (debugport != prev_q);
    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign push      = change && !full;
    assign head      = mem_q[rd_ptr_q];
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef DEBUGPORT_HEX_EN
        byte_d    = byte_q;
        chr_d     = chr_q;
`endif
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop       = 1'b1;
                    baud_d    = '0;
                    bit_cnt_d = 3'd0;
                    state_d   = START;
`ifdef DEBUGPORT_HEX_EN
                    byte_d    = head;
                    chr_d     = 2'd0;
                    shift_d   = char_sel(head, 2'd0);
`else
                    shift_d   = head;
`endif
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d    = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
`ifdef DEBUGPORT_HEX_EN
                    // remaining characters of the same entry follow without an idle cycle
                    if (chr_q != 2'd3) begin
                        chr_d     = chr_q + 2'd1;
                        shift_d   = char_sel(byte_q, chr_q + 2'd1);
                        bit_cnt_d = 3'd0;
                        state_d   = START;
                    end
`endif
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // line level is registered from the next state so uart_tx never glitches
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            prev_q     <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
`ifdef DEBUGPORT_HEX_EN
            byte_q     <= 8'h00;
            chr_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            prev_q     <= debugport;
            level_q    <= level_d;
            if (push)          wr_ptr_q   <= wr_ptr_q + PW'(1);
            if (pop)           rd_ptr_q   <= rd_ptr_q + PW'(1);
            if (change && full) overflow_q <= 1'b1;
`ifdef DEBUGPORT_HEX_EN
            byte_q     <= byte_d;
            chr_q      <= chr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= debugport;
    end

    assign uart_tx    = tx_q;
    assign busy       = (state_q != IDLE) || (level_q != '0);
    assign overflow   = overflow_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_debugport_uart_tx.sv
// Randomised and directed bench for debugport_uart_tx against a timeline model of the serial line.
module tb_debugport_uart_tx;
    localparam int C = 4;
    localparam int D = 4;
`ifdef DEBUGPORT_HEX_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 1;
`endif
    localparam int FRAME_CYC = NCH * 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dbg = 8'h00;
    logic       tx, busy, ovf;
    logic [2:0] lvl;

    debugport_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .debugport(dbg),
        .uart_tx(tx), .busy(busy), .overflow(ovf), .fifo_level(lvl)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n) - 8'd10;
    endfunction

    // characters sent for one queued byte
    function automatic logic [7:0] char_of(input logic [7:0] b, input int i);
`ifdef DEBUGPORT_HEX_EN
        case (i)
            0:       return hexc(b[7:4]);
            1:       return hexc(b[3:0]);
            2:       return 8'h0D;
            default: return 8'h0A;
        endcase
`else
        if (i == 0) return b;
        return 8'h00;
`endif
    endfunction

    // model: FIFO as a queue, transmission as a bit timeline indexed by elapsed cycles
    byte unsigned m_q[$];
    byte unsigned m_sent[$];
    bit           m_bits[$];
    int           m_cnt  = 0;
    bit           m_act  = 1'b0;
    logic [7:0]   m_prev = 8'h00;
    bit           m_ovf  = 1'b0;

    task automatic load_bits(input logic [7:0] b);
        logic [7:0] c;
        m_bits.delete();
        for (int k = 0; k < NCH; k++) begin
            c = char_of(b, k);
            m_bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) m_bits.push_back(c[j]);
            m_bits.push_back(1'b1);
        end
    endtask

    always @(posedge clk) begin
        bit         pop;
        logic [7:0] hd;
        if (rst) begin
            m_q.delete();
            m_bits.delete();
            m_act  = 1'b0;
            m_cnt  = 0;
            m_prev = 8'h00;
            m_ovf  = 1'b0;
        end else begin
            pop = !m_act && (m_q.size() != 0);
            if (m_act) begin
                m_cnt++;
                if (m_cnt == m_bits.size() * C) m_act = 1'b0;
            end else if (pop) begin
                hd = m_q.pop_front();
                m_sent.push_back(hd);
                load_bits(hd);
                m_act = 1'b1;
                m_cnt = 0;
            end
            if (dbg != m_prev) begin
                if (m_q.size() + (pop ? 1 : 0) == D) m_ovf = 1'b1;
                else m_q.push_back(dbg);
            end
            m_prev = dbg;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            if (rst) begin
                chk("rst_tx", tx, 1);
                chk("rst_busy", busy, 0);
                chk("rst_level", lvl, 0);
                chk("rst_ovf", ovf, 0);
            end else begin
                chk("tx", tx, m_act ? int'(m_bits[m_cnt / C]) : 1);
                chk("busy", busy, (m_act || m_q.size() != 0) ? 1 : 0);
                chk("level", lvl, m_q.size());
                chk("ovf", ovf, m_ovf);
            end
        end
    end

    // mid-bit sampling receiver on the DUT line
    byte unsigned rx_q[$];
    byte unsigned ex_q[$];
    bit           rx_act = 1'b0;
    int           rx_cnt = 0;
    logic [7:0]   rx_sh  = 8'h00;

    always @(negedge clk) begin
        int b;
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % C == C / 2) begin
                b = rx_cnt / C;
                if (b >= 1 && b <= 8) rx_sh[b-1] = tx;
                else if (b == 9) begin
                    chk("rx_stop", tx, 1);
                    rx_act = 1'b0;
                    rx_q.push_back(rx_sh);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_exp(input logic [7:0] b);
        for (int k = 0; k < NCH; k++) ex_q.push_back(char_of(b, k));
    endtask

    task automatic chk_rx(input string name);
        chk({name, "_count"}, rx_q.size(), ex_q.size());
        for (int i = 0; i < rx_q.size() && i < ex_q.size(); i++)
            chk({name, "_byte"}, rx_q[i], ex_q[i]);
        rx_q.delete();
        ex_q.delete();
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc && busy; i++) step(1);
        chk("wait_idle", busy, 0);
        step(2);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        step(2);
        cmp_en = 1'b1;
        chk("t1_rst_tx", tx, 1);
        chk("t1_rst_busy", busy, 0);
        rst = 1'b0;
        step(100);
        chk("t1_tx", tx, 1);
        chk("t1_busy", busy, 0);
        chk("t1_level", lvl, 0);
        chk("t1_ovf", ovf, 0);
        chk("t1_rx", rx_q.size(), 0);

        step(10);
        dbg = 8'hA5;
        step(1);
        chk("t2_push_level", lvl, 1);
        chk("t2_push_tx", tx, 1);
        step(1);
        chk("t2_start_tx", tx, 0);
        chk("t2_pop_level", lvl, 0);
        chk("t2_busy", busy, 1);
        step(3);
        chk("t2_start_end", tx, 0);
        step(1);
        chk("t2_bit0", tx, 1);
        step(4);
        chk("t2_bit1", tx, 0);
        step(FRAME_CYC - 9);
        chk("t2_busy_last", busy, 1);
        step(1);
        chk("t2_busy_fall", busy, 0);
        step(2);
        add_exp(8'hA5);
        chk_rx("t2_rx");

        for (int v = 1; v <= 6; v++) begin
            dbg = 8'(v);
            step(1);
        end
        wait_idle(2000);
        chk("t3_ovf", ovf, 1);
        for (int v = 1; v <= 5; v++) add_exp(8'(v));
        chk_rx("t3_rx");

        dbg = 8'h33;
        step(200);
        wait_idle(2000);
        chk("t4_ovf_sticky", ovf, 1);
        add_exp(8'h33);
        chk_rx("t4_rx");

        dbg = 8'h80;
        step(3);
        dbg = 8'h11;
        step(1);
        dbg = 8'h22;
        step(1);
        chk("t5_queued", lvl, 2);
        step(12);
        chk("t5_tx_before", tx, 0);
        dbg = 8'h00;
        rst = 1'b1;
        #1;
        chk("t5_async_tx", tx, 1);
        chk("t5_async_level", lvl, 0);
        chk("t5_async_busy", busy, 0);
        step(2);
        rst = 1'b0;
        step(100);
        chk("t5_no_frames", rx_q.size(), 0);
        chk("t5_busy", busy, 0);
        chk("t5_ovf", ovf, 0);

        dbg = 8'h3C;
        step(2);
        chk("t6_start", tx, 0);
        step(FRAME_CYC - 1);
        chk("t6_busy_last", busy, 1);
        step(1);
        chk("t6_busy_fall", busy, 0);
        step(2);
`ifdef DEBUGPORT_HEX_EN
        ex_q.push_back(8'h33);
        ex_q.push_back(8'h43);
        ex_q.push_back(8'h0D);
        ex_q.push_back(8'h0A);
`else
        ex_q.push_back(8'h3C);
`endif
        chk_rx("t6_rx");

        m_sent.delete();
        for (int n = 0; n < 300; n++) begin
            dbg  = 8'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 200)) : int'($urandom_range(1, 4));
            step(hold);
        end
        wait_idle(20000);
        for (int i = 0; i < m_sent.size(); i++) add_exp(m_sent[i]);
        chk_rx("rand_rx");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
